// File: rtl/fetch_unit_if.sv
`default_nettype none
// ============================================================================
//  Module     : fetch_unit_if
//  Description: Bus bundle between the fetch unit, the synchronous
//               instruction memory and the cpu control FSM.
//               master modport = fetch unit side, slave = memory/cpu side.
//  Signals    : mem_addr   instruction address (= pc)
//               mem_rd_en  read strobe, data valid on the next cycle
//               mem_rdata  instruction memory read data
//               d_inst     registered instruction presented to the cpu
//               run        one-cycle issue pulse
//               done       cpu completion pulse
//               cmp        compare flags, sampled together with done
//  Revision   : 1.0  initial release
// ============================================================================
interface fetch_unit_if #(
  parameter int ADDR_W = 8,
  parameter int INST_W = 16
);
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd_en;
  logic [INST_W-1:0] mem_rdata;
  logic [INST_W-1:0] d_inst;
  logic              run;
  logic              done;
  logic [1:0]        cmp;

  modport master (
    output mem_addr,
    output mem_rd_en,
    output d_inst,
    output run,
    input  mem_rdata,
    input  done,
    input  cmp
  );

  modport slave (
    input  mem_addr,
    input  mem_rd_en,
    input  d_inst,
    input  run,
    output mem_rdata,
    output done,
    output cmp
  );
endinterface
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module     : fetch_unit
//  Description: Instruction sequencer feeding the cpu control FSM. Holds the
//               PC, reads a synchronous instruction ROM, presents each
//               instruction on d_inst with a one-cycle run pulse, waits for
//               done and then advances the PC. Branch-format instructions
//               (d_inst[1:0] == 2'b10) are resolved here from the cmp flags.
//               Also provides start/stop control, a saturating retired-
//               instruction counter and a done-timeout watchdog.
//  Ports      : clk          clock, all state on the rising edge
//               reset        asynchronous active-low reset
//               start        one-cycle request to begin fetching at pc
//               stop         one-cycle request to halt after the current inst
//               bus          fetch_unit_if.master (memory + cpu handshake)
//               busy         high in every state except IDLE
//               pc           current program counter
//               inst_count   retired instructions, saturates at 16'hFFFF
//               err_timeout  sticky, done not seen within TIMEOUT WAIT cycles
//  Parameters : ADDR_W (8), INST_W (16), TIMEOUT (15, must be >= 4)
//  Revision   : 1.0  initial release
// ============================================================================
module fetch_unit #(
  parameter int ADDR_W  = 8,
  parameter int INST_W  = 16,
  parameter int TIMEOUT = 15
) (
  input  wire logic          clk,
  input  wire logic          reset,
  input  wire logic          start,
  input  wire logic          stop,
  fetch_unit_if.master       bus,
  output logic               busy,
  output logic [ADDR_W-1:0]  pc,
  output logic [15:0]        inst_count,
  output logic               err_timeout
);

  localparam int                c_wdog_w    = $clog2(TIMEOUT + 1);
  // WAIT may last at most TIMEOUT cycles; the counter holds (cycles - 1).
  localparam logic [c_wdog_w-1:0] c_wdog_last = c_wdog_w'(TIMEOUT - 1);
  localparam logic [15:0]       c_count_max = 16'hFFFF;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LOAD  = 3'd2,
    S_ISSUE = 3'd3,
    S_WAIT  = 3'd4
  } state_t;

  state_t              r_state;
  state_t              w_next_state;

  logic [ADDR_W-1:0]   r_pc;
  logic [INST_W-1:0]   r_d_inst;
  logic [15:0]         r_count;
  logic                r_run;
  logic                r_rd_en;
  logic                r_busy;
  logic                r_err;
  logic                r_stop_pend;
  logic [c_wdog_w-1:0] r_wdog;

  logic                w_retire;
  logic                w_timeout;
  logic                w_launch;
  logic                w_is_branch;
  logic [1:0]          w_cond;
  logic                w_taken;
  logic [ADDR_W-1:0]   w_target;
  logic [ADDR_W-1:0]   w_pc_next;

  // --------------------------------------------------------------------------
  // Branch resolution against the flags delivered with done
  // --------------------------------------------------------------------------
  assign w_is_branch = (r_d_inst[1:0] == 2'b10);
  assign w_cond      = r_d_inst[3:2];
  // cond 2'b11 is the "never" encoding, regardless of cmp.
  assign w_taken     = w_is_branch && (w_cond == bus.cmp) && (w_cond != 2'b11);
  assign w_target    = r_d_inst[ADDR_W+3:4];
  // Sequential increment wraps naturally at ADDR_W bits.
  assign w_pc_next   = w_taken ? w_target : (r_pc + ADDR_W'(1));

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    w_retire     = 1'b0;
    w_timeout    = 1'b0;
    w_launch     = 1'b0;
    case (r_state)
      S_IDLE: begin
        // stop has priority over a simultaneous start.
        if (start && !stop) begin
          w_next_state = S_FETCH;
          w_launch     = 1'b1;
        end
      end
      S_FETCH: w_next_state = S_LOAD;
      S_LOAD:  w_next_state = S_ISSUE;
      S_ISSUE: w_next_state = S_WAIT;
      S_WAIT: begin
        // done is checked first so it beats a timeout in the same cycle.
        if (bus.done) begin
          w_retire = 1'b1;
          // A stop arriving together with done still halts after this inst.
          w_next_state = (r_stop_pend || stop) ? S_IDLE : S_FETCH;
        end else if (r_wdog == c_wdog_last) begin
          w_timeout    = 1'b1;
          w_next_state = S_IDLE;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Registered outputs and datapath
  // --------------------------------------------------------------------------
  // Strobes are decoded from the next state so they are registered yet line
  // up exactly with the FETCH / ISSUE cycles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc        <= '0;
      r_d_inst    <= '0;
      r_count     <= '0;
      r_run       <= 1'b0;
      r_rd_en     <= 1'b0;
      r_busy      <= 1'b0;
      r_err       <= 1'b0;
      r_stop_pend <= 1'b0;
      r_wdog      <= '0;
    end else begin
      r_run   <= (w_next_state == S_ISSUE);
      r_rd_en <= (w_next_state == S_FETCH);
      r_busy  <= (w_next_state != S_IDLE);

      // Memory data requested in FETCH is valid during LOAD.
      if (r_state == S_LOAD) begin
        r_d_inst <= bus.mem_rdata;
      end

      if (r_state == S_ISSUE) begin
        r_wdog <= '0;
      end else if (r_state == S_WAIT) begin
        r_wdog <= r_wdog + c_wdog_w'(1);
      end

      if (w_retire) begin
        r_pc <= w_pc_next;
        if (r_count != c_count_max) begin
          r_count <= r_count + 16'd1;
        end
      end

      if (w_timeout) begin
        r_err <= 1'b1;
      end else if (w_launch) begin
        r_err <= 1'b0;
      end

      // Any path back to IDLE drops a pending stop; stop in IDLE is a no-op.
      if (w_next_state == S_IDLE) begin
        r_stop_pend <= 1'b0;
      end else if (stop && (r_state != S_IDLE)) begin
        r_stop_pend <= 1'b1;
      end
    end
  end

  assign bus.mem_addr  = r_pc;
  assign bus.mem_rd_en = r_rd_en;
  assign bus.d_inst    = r_d_inst;
  assign bus.run       = r_run;

  assign busy        = r_busy;
  assign pc          = r_pc;
  assign inst_count  = r_count;
  assign err_timeout = r_err;

endmodule
`default_nettype wire
